// File: rtl/branch_target_buffer_if.sv
// Fetch/execute side of the branch target buffer: lookup and training signals.
// Fetch drives pc, execute drives upd_*; the buffer answers on prepc/hit_predict.
interface branch_target_buffer_if #(
    parameter int PC_W = 13
);
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] prepc;
    logic            hit_predict;
    logic            upd_en;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;

    modport master (
        output pc,
        output upd_en,
        output upd_pc,
        output upd_target,
        output upd_taken,
        input  prepc,
        input  hit_predict
    );

    modport slave (
        input  pc,
        input  upd_en,
        input  upd_pc,
        input  upd_target,
        input  upd_taken,
        output prepc,
        output hit_predict
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters, combinational lookup.
// Optional BTB_STATS_EN adds lookup/hit/mispredict counters.
module branch_target_buffer #(
    parameter int PC_W       = 13,
    parameter int INDEX_BITS = 6
) (
    input  logic CLK,
    input  logic NRST,
    branch_target_buffer_if.slave bp
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_lookup,
    output logic [31:0] stat_hit,
    output logic [31:0] stat_mispred
`endif
);
    localparam int TAG_W   = PC_W - INDEX_BITS;
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [PC_W-1:0]  target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]      rd_tag;
    logic [TAG_W-1:0]      wr_tag;
    logic                  rd_hit;
    logic                  wr_match;

    assign rd_idx = bp.pc[INDEX_BITS-1:0];
    assign rd_tag = bp.pc[PC_W-1:INDEX_BITS];
    assign wr_idx = bp.upd_pc[INDEX_BITS-1:0];
    assign wr_tag = bp.upd_pc[PC_W-1:INDEX_BITS];

    // Lookup sees only registered state: no bypass of a same-cycle update.
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag)
                    && ctr_q[rd_idx][1];
    assign wr_match = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    assign bp.hit_predict = rd_hit;
    assign bp.prepc       = rd_hit ? target_q[rd_idx] : '0;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bp.upd_en) begin
            if (wr_match) begin
                if (bp.upd_taken) begin
                    if (ctr_q[wr_idx] != 2'b11)
                        ctr_d[wr_idx] = ctr_q[wr_idx] + 2'b01;
                    target_d[wr_idx] = bp.upd_target;
                end else if (ctr_q[wr_idx] != 2'b00) begin
                    ctr_d[wr_idx] = ctr_q[wr_idx] - 2'b01;
                end
            end else if (bp.upd_taken) begin
                // Not-taken misses never allocate.
                valid_d[wr_idx]  = 1'b1;
                tag_d[wr_idx]    = wr_tag;
                target_d[wr_idx] = bp.upd_target;
                ctr_d[wr_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_lookup_q;
    logic [31:0] stat_lookup_d;
    logic [31:0] stat_hit_q;
    logic [31:0] stat_hit_d;
    logic [31:0] stat_mispred_q;
    logic [31:0] stat_mispred_d;
    logic        wr_pred;
    logic        wr_wrong;

    assign wr_pred  = wr_match && ctr_q[wr_idx][1];
    assign wr_wrong = (wr_pred != bp.upd_taken)
                      || (wr_pred && (target_q[wr_idx] != bp.upd_target));

    always_comb begin
        stat_lookup_d  = stat_lookup_q + 32'd1;
        stat_hit_d     = stat_hit_q;
        stat_mispred_d = stat_mispred_q;
        if (rd_hit)
            stat_hit_d = stat_hit_q + 32'd1;
        if (bp.upd_en && wr_wrong)
            stat_mispred_d = stat_mispred_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            stat_lookup_q  <= '0;
            stat_hit_q     <= '0;
            stat_mispred_q <= '0;
        end else begin
            stat_lookup_q  <= stat_lookup_d;
            stat_hit_q     <= stat_hit_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    assign stat_lookup  = stat_lookup_q;
    assign stat_hit     = stat_hit_q;
    assign stat_mispred = stat_mispred_q;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: lookup, training, alias, reset.
// Stats checks are compiled in when BTB_STATS_EN is defined.
module tb_branch_target_buffer;
    localparam int PC_W = 13;

    logic CLK;
    logic NRST;
    int   n_run;
    int   n_fail;

    branch_target_buffer_if #(.PC_W(PC_W)) bp ();

`ifdef BTB_STATS_EN
    logic [31:0] stat_lookup;
    logic [31:0] stat_hit;
    logic [31:0] stat_mispred;
`endif

    branch_target_buffer #(.PC_W(PC_W), .INDEX_BITS(6)) dut (
        .CLK  (CLK),
        .NRST (NRST),
        .bp   (bp.slave)
`ifdef BTB_STATS_EN
        ,
        .stat_lookup  (stat_lookup),
        .stat_hit     (stat_hit),
        .stat_mispred (stat_mispred)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic [PC_W-1:0] p, input logic [PC_W-1:0] t,
                       input logic tk);
        bp.upd_en     = 1'b1;
        bp.upd_pc     = p;
        bp.upd_target = t;
        bp.upd_taken  = tk;
        tick();
        bp.upd_en = 1'b0;
    endtask

    task automatic look(input string tag, input logic [PC_W-1:0] p,
                        input logic h, input logic [PC_W-1:0] t);
        bp.pc = p;
        #1;
        chk({tag, ".hit"}, 32'(bp.hit_predict), 32'(h));
        chk({tag, ".prepc"}, 32'(bp.prepc), 32'(t));
    endtask

    initial begin
        n_run         = 0;
        n_fail        = 0;
        NRST          = 1'b0;
        bp.pc         = '0;
        bp.upd_en     = 1'b0;
        bp.upd_pc     = '0;
        bp.upd_target = '0;
        bp.upd_taken  = 1'b0;
        #2;
        look("rst", 13'h010, 1'b0, 13'h000);
        tick();
        tick();
        NRST = 1'b1;

        for (int i = 0; i < 64; i++) begin
            bp.pc = PC_W'(i);
            #1;
            chk("sweep", {18'd0, bp.hit_predict, bp.prepc}, 32'd0);
        end

        upd(13'h010, 13'h040, 1'b1);
        look("alloc", 13'h010, 1'b1, 13'h040);

        upd(13'h010, 13'h040, 1'b0);
        look("nt1", 13'h010, 1'b0, 13'h000);
        upd(13'h010, 13'h040, 1'b0);
        upd(13'h010, 13'h040, 1'b0);
        look("nt3", 13'h010, 1'b0, 13'h000);
        upd(13'h010, 13'h040, 1'b1);
        look("tk1", 13'h010, 1'b0, 13'h000);
        upd(13'h010, 13'h040, 1'b1);
        look("tk2", 13'h010, 1'b1, 13'h040);
        upd(13'h010, 13'h040, 1'b1);
        upd(13'h010, 13'h040, 1'b1);
        upd(13'h010, 13'h040, 1'b0);
        look("sat_hi", 13'h010, 1'b1, 13'h040);
        upd(13'h010, 13'h041, 1'b1);
        look("retarget", 13'h010, 1'b1, 13'h041);

        upd(13'h050, 13'h123, 1'b1);
        look("alias_old", 13'h010, 1'b0, 13'h000);
        look("alias_new", 13'h050, 1'b1, 13'h123);
        upd(13'h010, 13'h777, 1'b0);
        look("alias_nt", 13'h050, 1'b1, 13'h123);

        bp.pc         = 13'h020;
        bp.upd_en     = 1'b1;
        bp.upd_pc     = 13'h020;
        bp.upd_target = 13'h0AA;
        bp.upd_taken  = 1'b1;
        #1;
        chk("same.hit", 32'(bp.hit_predict), 32'd0);
        tick();
        bp.upd_en = 1'b0;
        chk("same.next.hit", 32'(bp.hit_predict), 32'd1);
        chk("same.next.prepc", 32'(bp.prepc), 32'h0AA);

        upd(13'h030, 13'h055, 1'b0);
        look("nt_empty", 13'h030, 1'b0, 13'h000);

        upd(13'h001, 13'h100, 1'b1);
        upd(13'h002, 13'h200, 1'b1);
        upd(13'h003, 13'h300, 1'b1);
        upd(13'h004, 13'h400, 1'b1);
        look("pre_rst", 13'h003, 1'b1, 13'h300);
        bp.upd_en     = 1'b1;
        bp.upd_pc     = 13'h005;
        bp.upd_target = 13'h500;
        bp.upd_taken  = 1'b1;
        NRST          = 1'b0;
        #1;
        chk("arst.hit", 32'(bp.hit_predict), 32'd0);
        chk("arst.prepc", 32'(bp.prepc), 32'd0);
`ifdef BTB_STATS_EN
        chk("arst.lookup", stat_lookup, 32'd0);
        chk("arst.shit", stat_hit, 32'd0);
        chk("arst.mispred", stat_mispred, 32'd0);
`endif
        tick();
        bp.upd_en = 1'b0;
        bp.pc     = 13'h000;
        #1;
        NRST = 1'b1;
        look("post_rst.old", 13'h001, 1'b0, 13'h000);
        look("post_rst.inflight", 13'h005, 1'b0, 13'h000);

`ifdef BTB_STATS_EN
        bp.pc = 13'h000;
        upd(13'h007, 13'h070, 1'b1);
        bp.pc = 13'h007;
        tick();
        tick();
        tick();
        bp.pc = 13'h000;
        for (int i = 0; i < 6; i++) tick();
        chk("st.lookup", stat_lookup, 32'd10);
        chk("st.hit", stat_hit, 32'd3);
        chk("st.mispred", stat_mispred, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
